// File: rtl/tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tristate_bus_arbiter
// Purpose  : Round-robin arbiter granting N channels a shared tri-state bus,
//            with a per-grant hold limit and high-Z turnaround between owners.
// Revision : 1.0 - initial release
// ============================================================================
module tristate_bus_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int HOLD  = 4,
    parameter int TA    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [N-1:0]                          req,
    input  logic [N*WIDTH-1:0]                    din,
    output logic [N-1:0]                          gnt,
    output wire  [WIDTH-1:0]                      bus,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]  owner,
    output logic                                  busy
);

    localparam int c_OW  = (N > 1) ? $clog2(N) : 1;
    localparam int c_CW  = (HOLD < 2) ? 1 : $clog2(HOLD + 1);
    localparam int c_TCW = (TA < 2) ? 1 : $clog2(TA);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    generate
        if (N < 2) begin : g_bad_n
            $error("tristate_bus_arbiter: N must be at least 2");
        end
        if (TA < 1) begin : g_bad_ta
            $error("tristate_bus_arbiter: TA must be at least 1");
        end
    endgenerate

    state_t              r_state;
    logic [N-1:0]        r_gnt;
    logic [c_OW-1:0]     r_owner;
    logic [c_CW-1:0]     r_hold;
    logic [c_TCW-1:0]    r_ta;

    state_t              w_state_nxt;
    logic [N-1:0]        w_gnt_nxt;
    logic [c_OW-1:0]     w_owner_nxt;
    logic [c_CW-1:0]     w_hold_nxt;
    logic [c_TCW-1:0]    w_ta_nxt;

    logic                w_any;
    logic [c_OW-1:0]     w_win;
    logic [N-1:0]        w_win_onehot;
    logic                w_hold_done;
    logic                w_ta_done;
    logic                w_drive;
    logic [WIDTH-1:0]    w_data;

    // Search begins one past the last owner, so the previous owner comes last.
    function automatic logic [c_OW-1:0] f_rr_pick(input logic [N-1:0]    r,
                                                  input logic [c_OW-1:0] last);
        logic [c_OW-1:0] pick;
        logic            found;
        int              idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = c_OW'(idx);
            end
        end
        return pick;
    endfunction

    assign w_any        = |req;
    assign w_win        = f_rr_pick(req, r_owner);
    assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;
    assign w_hold_done  = (HOLD != 0) && (r_hold == c_CW'(HOLD));
    assign w_ta_done    = (r_ta == c_TCW'(TA - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
        w_ta_nxt    = r_ta;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                if (w_any) begin
                    w_state_nxt = S_DRIVE;
                    w_gnt_nxt   = w_win_onehot;
                    w_owner_nxt = w_win;
                    w_hold_nxt  = c_CW'(1);
                    w_ta_nxt    = '0;
                end
            end
            S_DRIVE: begin
                // Only the owner's own request and the hold limit end a grant.
                if (!req[r_owner] || w_hold_done) begin
                    w_state_nxt = S_TURN;
                    w_gnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_ta_nxt    = '0;
                end else if (r_hold != {c_CW{1'b1}}) begin
                    w_hold_nxt  = r_hold + c_CW'(1);
                end
            end
            S_TURN: begin
                w_gnt_nxt = '0;
                if (w_ta_done) begin
                    w_ta_nxt = '0;
                    if (w_any) begin
                        w_state_nxt = S_DRIVE;
                        w_gnt_nxt   = w_win_onehot;
                        w_owner_nxt = w_win;
                        w_hold_nxt  = c_CW'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_ta_nxt = r_ta + c_TCW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_hold_nxt  = '0;
                w_ta_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= c_OW'(N - 1);
            r_hold  <= '0;
            r_ta    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_hold  <= w_hold_nxt;
            r_ta    <= w_ta_nxt;
        end
    end

    assign w_drive = (r_state == S_DRIVE);
    assign w_data  = din[r_owner*WIDTH +: WIDTH];

    assign bus   = w_drive ? w_data : {WIDTH{1'bz}};
    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tristate_bus_arbiter
// Purpose  : Directed, table-driven self-checking bench for the bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_arbiter;

    localparam logic [7:0] c_REL = 8'hFF;   // released bus reads as pull-ups

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [7:0] bus;
        logic [1:0] owner;
        logic       busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req0;
    logic [31:0] din;
    logic [3:0]  gnt, gnt0;
    wire  [7:0]  bus, bus0;
    logic [1:0]  owner, owner0;
    logic        busy, busy0;

    logic [7:0]  dbyte [4];
    vec_t        tbl [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pu
            pullup (bus[gi]);
            pullup (bus0[gi]);
        end
    endgenerate

    tristate_bus_arbiter #(.WIDTH(8), .N(4), .HOLD(4), .TA(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt), .bus(bus), .owner(owner), .busy(busy)
    );

    tristate_bus_arbiter #(.WIDTH(8), .N(4), .HOLD(0), .TA(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .din(din),
        .gnt(gnt0), .bus(bus0), .owner(owner0), .busy(busy0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic [7:0] b, input logic [1:0] o, input logic bz);
        vec_t v;
        v.rst_n = r; v.req = rq; v.gnt = g; v.bus = b; v.owner = o; v.busy = bz;
        tbl.push_back(v);
    endtask

    task automatic add_rst(input logic [3:0] rq);
        add(1'b0, rq, 4'b0000, c_REL, 2'd3, 1'b0);
    endtask

    task automatic add_drive(input logic [3:0] rq, input int ch);
        add(1'b1, rq, 4'b0001 << ch, dbyte[ch], 2'(ch), 1'b1);
    endtask

    task automatic add_turn(input logic [3:0] rq, input int ch);
        add(1'b1, rq, 4'b0000, c_REL, 2'(ch), 1'b1);
    endtask

    task automatic add_idle(input logic [3:0] rq, input int ch);
        add(1'b1, rq, 4'b0000, c_REL, 2'(ch), 1'b0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // At most one grant, and the bus must be released whenever nobody owns it.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (!$onehot0(gnt)) begin
                n_bad++;
                $display("FAIL onehot gnt: got %b, required at most one bit", gnt);
            end
            if (gnt == 4'b0000) begin
                n_cmp++;
                if (bus !== c_REL) begin
                    n_bad++;
                    $display("FAIL released bus: got %h, expected %h", bus, c_REL);
                end
            end
        end
    end

    initial begin
        dbyte[0] = 8'hA5; dbyte[1] = 8'h5A; dbyte[2] = 8'h3C; dbyte[3] = 8'hC3;
        din   = {dbyte[3], dbyte[2], dbyte[1], dbyte[0]};
        rst_n = 1'b0;
        req   = 4'b0000;
        req0  = 4'b0000;

        // Two requesters alternate under the hold limit.
        add_rst(4'b0101);
        for (int i = 0; i < 4; i++) add_drive(4'b0101, 0);
        add_turn(4'b0101, 0);
        for (int i = 0; i < 4; i++) add_drive(4'b0101, 2);
        add_turn(4'b0101, 2);
        add_drive(4'b0101, 0);
        // Requests drop: turnaround then idle; then a lone short requester.
        add_turn(4'b0000, 0);
        add_idle(4'b0000, 0);
        add_drive(4'b1000, 3);
        add_drive(4'b1000, 3);
        add_turn(4'b0000, 3);
        add_idle(4'b0000, 3);
        // All four requesting: order 0,1,2,3,0.
        add_rst(4'b1111);
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) add_drive(4'b1111, g % 4);
            add_turn(4'b1111, g % 4);
        end
        // Lone requester is re-granted after its turnaround.
        add_rst(4'b0010);
        for (int i = 0; i < 4; i++) add_drive(4'b0010, 1);
        add_turn(4'b0010, 1);
        add_drive(4'b0010, 1);
        // Non-owner request during DRIVE is ignored; seen at the TURN edge.
        add_rst(4'b0000);
        add_drive(4'b0100, 2);
        add_turn(4'b0001, 2);
        add_drive(4'b0001, 0);

        step();
        step();
        mon_en = 1'b1;

        foreach (tbl[i]) begin
            rst_n = tbl[i].rst_n;
            req   = tbl[i].req;
            step();
            chk($sformatf("row%0d gnt", i),   32'(gnt),   32'(tbl[i].gnt));
            chk($sformatf("row%0d bus", i),   32'(bus),   32'(tbl[i].bus));
            chk($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].owner));
            chk($sformatf("row%0d busy", i),  32'(busy),  32'(tbl[i].busy));
        end

        // Reset in channel 1's second DRIVE cycle.
        rst_n = 1'b0; req = 4'b0000; step();
        rst_n = 1'b1; req = 4'b0010; step();
        chk("mid-drive c1 gnt", 32'(gnt), 32'(4'b0010));
        step();
        chk("mid-drive c2 gnt", 32'(gnt), 32'(4'b0010));
        rst_n = 1'b0; step();
        chk("mid-drive rst gnt",   32'(gnt),   32'(4'b0000));
        chk("mid-drive rst bus",   32'(bus),   32'(c_REL));
        chk("mid-drive rst owner", 32'(owner), 32'(2'd3));
        chk("mid-drive rst busy",  32'(busy),  32'(1'b0));
        rst_n = 1'b1; req = 4'b0011; step();
        chk("post-rst gnt",   32'(gnt),   32'(4'b0001));
        chk("post-rst owner", 32'(owner), 32'(2'd0));
        // Run channel 0 to its hold limit, then reset inside TURN.
        repeat (3) @(posedge clk);
        step();
        chk("hold turn gnt",  32'(gnt),  32'(4'b0000));
        chk("hold turn busy", 32'(busy), 32'(1'b1));
        rst_n = 1'b0; step();
        chk("mid-turn rst owner", 32'(owner), 32'(2'd3));
        chk("mid-turn rst busy",  32'(busy),  32'(1'b0));
        rst_n = 1'b1; step();
        chk("mid-turn post gnt", 32'(gnt), 32'(4'b0001));

        // Unlimited hold: one requester keeps the bus without any TURN.
        rst_n = 1'b0; req = 4'b0000; req0 = 4'b0000; step();
        rst_n = 1'b1; req0 = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("nohold c%0d gnt", i), 32'(gnt0), 32'(4'b0001));
            chk($sformatf("nohold c%0d bus", i), 32'(bus0), 32'(dbyte[0]));
        end
        req0 = 4'b0000; step();
        chk("nohold turn gnt",  32'(gnt0),  32'(4'b0000));
        chk("nohold turn busy", 32'(busy0), 32'(1'b1));
        step();
        chk("nohold idle busy", 32'(busy0), 32'(1'b0));
        chk("nohold idle bus",  32'(bus0),  32'(c_REL));

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width per channel and of the shared bus.
REQ-002 The block SHALL have parameter N, default 4, giving the number of requesting channels (N >= 2).
REQ-003 The block SHALL have parameter HOLD, default 4, giving the maximum consecutive DRIVE cycles per grant; 0 means unlimited.
REQ-004 The block SHALL have parameter TA, default 1, giving the turnaround cycles with the bus at high-Z between grants (TA >= 1).
REQ-005 Port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 Port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 Port req, input, N bits: bit i high means channel i requests the bus.
REQ-008 Port din, input, N*WIDTH bits: channel i data at bits [i*WIDTH +: WIDTH].
REQ-009 Port gnt, output, N bits: registered, one-hot or zero; bit i high means channel i owns the bus.
REQ-010 Port bus, output, WIDTH bits: shared bus, driven with din of the owner in DRIVE, otherwise all bits 1'bz.
REQ-011 Port owner, output, max(1,$clog2(N)) bits: registered index of the current or most recent owner.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DRIVE and TURN.
REQ-014 IDLE behaviour:
- gnt = 0, bus = Z.
- If any req bit is set at an edge, the block SHALL enter DRIVE on that edge, with gnt one-hot for the winner and owner updated.
REQ-015 Arbitration SHALL be round-robin.
- The search starts at (last owner + 1) mod N and wraps through N-1 to 0.
- The first set req bit wins.
REQ-016 Latency: req sampled high at edge k SHALL give gnt high and bus = din[owner] in the cycle after edge k (1-cycle grant latency), when arbitrating from IDLE.
REQ-017 In DRIVE, bus SHALL follow din[owner] combinationally in the same cycle; no other channel's data may appear on bus.
REQ-018 The DRIVE hold counter SHALL:
- load 1 on entry to DRIVE;
- increment on every further DRIVE cycle;
- saturate, with no wrap.
REQ-019 DRIVE exits to TURN at the edge where req[owner] is low, or where HOLD != 0 and the counter equals HOLD. gnt drops and bus goes Z on that same edge.
REQ-020 TURN SHALL last exactly TA cycles with gnt = 0 and bus = Z. At its final edge:
- If any req is set: enter DRIVE with a new round-robin winner.
- Otherwise: enter IDLE.
REQ-021 After TURN, the previous owner MAY be re-granted only if no other channel requests (round-robin from last owner + 1 guarantees this).
REQ-022 Requests that appear or disappear during TURN SHALL be evaluated only at the final TURN edge. Requests from non-owners during DRIVE SHALL NOT affect the current grant.
REQ-023 gnt SHALL never have more than one bit set. bus SHALL never be driven in the same cycle that any gnt bit transitions between two different owners (no contention).
REQ-024 owner SHALL hold its value through TURN and IDLE until the next grant.

Reset
REQ-025 With rst_n low at an edge, the following SHALL apply regardless of state, including mid-DRIVE and mid-TURN:
- state = IDLE, gnt = 0, bus = Z, busy = 0;
- hold counter = 0, turnaround counter = 0;
- owner = N-1, so channel 0 has highest priority after reset.
REQ-026 The first edge with rst_n high SHALL arbitrate normally per REQ-014.

Verification (WIDTH=8, N=4, HOLD=4, TA=1)
REQ-027 Reset then req=4'b0101 held, din0=8'hA5, din2=8'h3C:
- gnt=0001 and bus=A5 for 4 cycles;
- 1 TURN cycle with bus=ZZ;
- gnt=0100 and bus=3C for 4 cycles;
- TURN, then gnt=0001 again.
REQ-028 Single requester: req=4'b1000 for 2 cycles, then 0. The bench SHALL see:
- gnt=1000 for exactly 2 cycles;
- 1 TURN cycle;
- IDLE with busy=0 and bus=ZZ.
REQ-029 All four requesting continuously SHALL give the grant order 0,1,2,3,0 with one Z cycle between each grant and no cycle where two gnt bits are set.
REQ-030 Re-grant check: req=4'b0010 held with HOLD=4 SHALL give 4 cycles of gnt=0010, 1 TURN cycle, then gnt=0010 again.
REQ-031 Reset mid-operation: rst_n low in the 2nd DRIVE cycle of channel 1 SHALL give, next cycle, gnt=0, bus=ZZ and owner=3. After release with req=4'b0011, channel 0 SHALL be granted first.
REQ-032 A bench run with HOLD=0 and req=4'b0001 held for 20 cycles SHALL show gnt=0001 continuously with no TURN inserted.
